// File: rtl/tmds_decoder_if.sv
// Decoder-side bundle: serial TMDS input plus the decoded word, strobe and lock status.
interface tmds_decoder_if;
   logic       ser;
   logic [7:0] data;
   logic       de;
   logic [1:0] ctrl;
   logic       valid;
   logic       locked;

   modport master (input ser, output data, output de, output ctrl, output valid, output locked);
   modport slave  (output ser, input data, input de, input ctrl, input valid, input locked);
endinterface

// File: rtl/tmds_decoder.sv
// Single-channel TMDS deserialiser: finds symbol alignment from control tokens,
// then decodes each 10-bit symbol into a pixel byte or a control value.
module tmds_decoder #(
   parameter int LOCK_COUNT = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic           clk,
   input  logic           reset_n,
   tmds_decoder_if.master bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [9:0] TOK_00 = 10'b1101010100;
   localparam logic [9:0] TOK_01 = 10'b0010101011;
   localparam logic [9:0] TOK_10 = 10'b0101010100;
   localparam logic [9:0] TOK_11 = 10'b1010101011;

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t        state, state_nxt;
   logic [9:0]    sr_p0;
   logic [9:0]    win;
   logic [3:0]    bcnt;
   logic          boundary;
   logic          bcnt_clr;
   logic [3:0]    mcnt, mcnt_nxt;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic          capture;
   logic [9:0]    word_p1;
   logic          vld_p1;

   function automatic logic tok_hit(input logic [9:0] w);
      return (w == TOK_00) || (w == TOK_01) || (w == TOK_10) || (w == TOK_11);
   endfunction

   function automatic logic [1:0] tok_val(input logic [9:0] w);
      case (w)
         TOK_01:  return 2'b01;
         TOK_10:  return 2'b10;
         TOK_11:  return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [7:0] tmds_decode(input logic [9:0] w);
      logic [7:0] d;
      logic [7:0] r;
      d    = w[9] ? ~w[7:0] : w[7:0];
      r[0] = d[0];
      for (int i = 1; i < 8; i++) r[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      return r;
   endfunction

   // The window includes the bit arriving on this edge, so a match lines up with the symbol's last bit.
   assign win        = {bus.ser, sr_p0[9:1]};
   assign boundary   = (bcnt == 4'd9);
   assign bus.locked = (state == LOCKED);

   always_comb begin
      state_nxt = state;
      mcnt_nxt  = mcnt;
      tcnt_nxt  = tcnt;
      bcnt_clr  = 1'b0;
      capture   = 1'b0;
      case (state)
         SEARCH: begin
            if (tok_hit(win)) begin
               bcnt_clr  = 1'b1;
               mcnt_nxt  = 4'd1;
               state_nxt = VERIFY;
            end
         end
         VERIFY: begin
            if (boundary) begin
               if (tok_hit(win)) begin
                  mcnt_nxt = mcnt + 4'd1;
                  if (mcnt + 4'd1 == 4'(LOCK_COUNT)) begin
                     state_nxt = LOCKED;
                     tcnt_nxt  = '0;
                  end
               end else begin
                  mcnt_nxt  = '0;
                  state_nxt = SEARCH;
               end
            end
         end
         LOCKED: begin
            capture = boundary;
            // Timeout bookkeeping runs one clk after the boundary, alongside the output update.
            if (vld_p1) begin
               if (tok_hit(word_p1)) begin
                  tcnt_nxt = '0;
               end else if (tcnt != TW'(TIMEOUT)) begin
                  tcnt_nxt = tcnt + 1'b1;
                  if (tcnt + 1'b1 == TW'(TIMEOUT)) state_nxt = SEARCH;
               end
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= SEARCH;
         sr_p0     <= '0;
         bcnt      <= '0;
         mcnt      <= '0;
         tcnt      <= '0;
         word_p1   <= '0;
         vld_p1    <= 1'b0;
         bus.valid <= 1'b0;
         bus.data  <= '0;
         bus.de    <= 1'b0;
         bus.ctrl  <= '0;
      end else begin
         state   <= state_nxt;
         mcnt    <= mcnt_nxt;
         tcnt    <= tcnt_nxt;
         sr_p0   <= win;
         bcnt    <= (bcnt_clr || boundary) ? 4'd0 : bcnt + 4'd1;
         // stage p1: captured symbol waits one clk before decode
         vld_p1  <= capture;
         if (capture) word_p1 <= win;
         // stage p2: registered decoded outputs
         bus.valid <= vld_p1;
         if (vld_p1) begin
            if (tok_hit(word_p1)) begin
               bus.de   <= 1'b0;
               bus.ctrl <= tok_val(word_p1);
               bus.data <= '0;
            end else begin
               bus.de   <= 1'b1;
               bus.data <= tmds_decode(word_p1);
            end
         end
      end
   end
endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: reset, offset lock, decode, verify failure,
// timeout-driven lock loss and reset while locked.
module tb_tmds_decoder;
   localparam logic [9:0] TOK00 = 10'b1101010100;
   localparam logic [9:0] TOK01 = 10'b0010101011;
   localparam logic [9:0] W100  = 10'h100;
   localparam logic [9:0] W200  = 10'h200;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   vcnt = 0;
   int   last_cyc = 0;
   int   prev_cyc = 0;
   int   base;

   tmds_decoder_if bus();

   tmds_decoder #(.LOCK_COUNT(4), .TIMEOUT(1024)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.valid) begin
         vcnt     <= vcnt + 1;
         last_cyc <= cyc;
         prev_cyc <= last_cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      bus.ser = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [9:0] w);
      for (int i = 0; i < 10; i++) send_bit(w[i]);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      bus.ser = 1'b0;
      reset_n = 1'b1;
      repeat (3) send_bit(1'b1);

      // reset mid-cycle takes effect without a clock edge
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_data",   32'(bus.data),   32'h0);
      check("rst_de",     32'(bus.de),     32'h0);
      check("rst_ctrl",   32'(bus.ctrl),   32'h0);
      check("rst_valid",  32'(bus.valid),  32'h0);
      check("rst_locked", 32'(bus.locked), 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // lock with a 3-bit offset
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      repeat (3) send_word(TOK00);
      for (int i = 0; i < 9; i++) send_bit(TOK00[i]);
      check("lock_before_40", 32'(bus.locked), 32'h0);
      send_bit(TOK00[9]);
      check("lock_at_40",   32'(bus.locked), 32'h1);
      check("lock_ctrl",    32'(bus.ctrl),   32'h0);
      check("lock_valid",   32'(bus.valid),  32'h0);
      check("lock_nopulse", 32'(vcnt),       32'h0);

      // decode three words
      send_word(W100);
      send_bit(W200[0]);
      check("dec0_valid", 32'(bus.valid), 32'h1);
      check("dec0_data",  32'(bus.data),  32'h00);
      check("dec0_de",    32'(bus.de),    32'h1);
      check("dec0_ctrl",  32'(bus.ctrl),  32'h0);
      for (int i = 1; i < 10; i++) send_bit(W200[i]);
      send_bit(TOK01[0]);
      check("dec1_valid", 32'(bus.valid), 32'h1);
      check("dec1_data",  32'(bus.data),  32'hFF);
      check("dec1_de",    32'(bus.de),    32'h1);
      check("dec1_ctrl",  32'(bus.ctrl),  32'h0);
      for (int i = 1; i < 10; i++) send_bit(TOK01[i]);
      send_bit(1'b0);
      check("dec2_valid", 32'(bus.valid), 32'h1);
      check("dec2_data",  32'(bus.data),  32'h00);
      check("dec2_de",    32'(bus.de),    32'h0);
      check("dec2_ctrl",  32'(bus.ctrl),  32'h1);
      repeat (3) send_bit(1'b0);
      check("dec_pulse_end", 32'(bus.valid),          32'h0);
      check("dec_count",     32'(vcnt),               32'd3);
      check("dec_spacing",   32'(last_cyc - prev_cyc), 32'd10);

      // reset mid-word while locked
      check("pre_rst_locked", 32'(bus.locked), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rstl_locked", 32'(bus.locked), 32'h0);
      check("rstl_ctrl",   32'(bus.ctrl),   32'h0);
      check("rstl_de",     32'(bus.de),     32'h0);
      check("rstl_valid",  32'(bus.valid),  32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (3) send_word(TOK00);
      for (int i = 0; i < 9; i++) send_bit(TOK00[i]);
      check("relock_39", 32'(bus.locked), 32'h0);
      send_bit(TOK00[9]);
      check("relock_40", 32'(bus.locked), 32'h1);

      // verify failure returns to search
      do_reset();
      base = vcnt;
      send_word(TOK00);
      send_word(W100);
      send_bit(1'b0);
      check("vfail_locked", 32'(bus.locked), 32'h0);
      check("vfail_valid",  32'(bus.valid),  32'h0);
      do_reset();
      send_word(TOK00);
      send_word(W100);
      repeat (3) send_word(TOK00);
      check("vfail_3tok", 32'(bus.locked), 32'h0);
      send_word(TOK00);
      check("vfail_4tok", 32'(bus.locked), 32'h1);
      check("vfail_nopulse", 32'(vcnt - base), 32'h0);

      // timeout after 1024 data words
      do_reset();
      repeat (4) send_word(TOK00);
      base = vcnt;
      repeat (1023) send_word(W100);
      send_word(W100);
      check("to_locked_before", 32'(bus.locked), 32'h1);
      send_bit(W100[0]);
      check("to_last_valid", 32'(bus.valid),  32'h1);
      check("to_locked_drop", 32'(bus.locked), 32'h0);
      for (int i = 1; i < 10; i++) send_bit(W100[i]);
      repeat (5) send_word(W100);
      check("to_pulses",   32'(vcnt - base), 32'd1024);
      check("to_stay_off", 32'(bus.locked),  32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 4: consecutive aligned control tokens needed to declare lock (range 2..15).
REQ-002 Parameter TIMEOUT, default 1024: words allowed in LOCKED without a control token before lock is dropped.
REQ-003 clk  input  1  serial bit clock; one TMDS bit per rising edge (10 clocks per pixel).
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 ser  input  1  serial TMDS channel; LSB of each 10-bit symbol first.
REQ-006 data  output  8  decoded pixel byte, registered.
REQ-007 de  output  1  1 = last word was a data symbol; 0 = control token.
REQ-008 ctrl  output  2  control bits of the last control token, held through data periods.
REQ-009 valid  output  1  one-clk strobe per decoded word, LOCKED state only.
REQ-010 locked  output  1  1 while the state machine is in LOCKED.

Function
REQ-011 Shift register: each clk, ser enters bit 9 and the register shifts right; after 10 bits, bit 0 holds the first bit received (q[0]).
REQ-012 Control tokens: 10'b1101010100 = ctrl 00; 10'b0010101011 = 01; 10'b0101010100 = 10; 10'b1010101011 = 11.
REQ-013 Bit counter: 0..9 wraps; the word boundary is the clk at which counter = 9 and the 10th bit is shifted in.
REQ-014 States: SEARCH, VERIFY, LOCKED; encoding is free.
REQ-015 SEARCH: every clk, compare the 10-bit window including the bit just shifted in against the four tokens.
  - on match: bit counter := 0, match count := 1, go to VERIFY.
REQ-016 VERIFY: at each word boundary:
  - token: match count++; when match count reaches LOCK_COUNT, go to LOCKED.
  - non-token: go to SEARCH with match count := 0.
REQ-017 LOCKED: at each word boundary:
  - decode the word; data/de/ctrl update on the next clk edge; valid pulses high for exactly that one clk.
  - latency: last symbol bit sampled at edge N; outputs and valid change at edge N+1.
REQ-018 Token word: de := 0, ctrl := token value, data := 0.
REQ-019 Non-token word: de := 1; ctrl holds its value.
  - d = q[9] ? ~q[7:0] : q[7:0]; data[0] = d[0].
  - for i = 1..7: data[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-020 Timeout counter: clears on every token word in LOCKED and increments on every non-token word; saturates at TIMEOUT and never wraps.
REQ-021 Lock loss: when a non-token word brings the counter to TIMEOUT, still output that word (valid=1), then go to SEARCH on the same edge; locked falls with the valid pulse.
REQ-022 locked rises at the edge that enters LOCKED; valid stays 0 on that edge, and the first valid word is the next one.
REQ-023 Outside LOCKED: valid = 0; data, de and ctrl hold their last values.
REQ-024 The bit counter and shift register run in every state; re-entering SEARCH does not clear the shift register.

Reset
REQ-025 reset_n low immediately forces, without waiting for clk:
  - data = 0, de = 0, ctrl = 00, valid = 0, locked = 0;
  - state = SEARCH; shift register, bit counter, match count and timeout counter = 0.
REQ-026 Reset asserted mid-word or while LOCKED discards the partial word; after release, alignment restarts from SEARCH.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
  - Reset: drive reset_n = 0 at any time -> all outputs 0 within the same time step, state SEARCH.
  - Lock with offset: 3 random bits, then 4x token 1101010100 -> locked = 1 at the edge after the 40th token bit; ctrl = 00, valid stays 0.
  - Decode: once locked, send 0x100, 0x200, then 0010101011 -> three valid pulses 10 clks apart with (data, de, ctrl) = (00,1,00), (FF,1,00), (00,0,01).
  - Verify failure: 1 token, then 0x100 -> no valid pulse, locked stays 0, state returns to SEARCH.
  - Timeout: lock, then 1024 consecutive words 0x100 -> 1024 valid pulses; locked falls with the 1024th; no further valid pulses.
  - Reset while locked: reset_n low mid-word -> locked = 0 immediately; after release, 4 tokens relock in 40 clks.
